// File: rtl/axis_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_sdram_pkg
// Purpose : Shared types and helpers for the multi-channel AXI4-Stream to
//           SDRAM write engine (FSM state type, counter width helper).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package axis_sdram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wr_state_t;

  // Ceil-log2, never less than 1 so that single-entry counters and
  // single-channel indices still get a legal one-bit vector.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. Searches the request vector
//           starting one position after the last grant and wrapping modulo N.
// Ports   : req        in  N      request per requester
//           last       in  IDX_W  index of the previous grant
//           grant      out N      one-hot grant (zero when nothing requests)
//           grant_idx  out IDX_W  index of the granted requester
//           any        out 1      at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // The last-granted requester is visited last (i == N), so it only wins
    // again when nobody else is asking.
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(last) + i) % N;
      cand_idx = cand[IDX_W-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_sdram_mc_writer.sv
`default_nettype none
// ============================================================================
// Module  : axis_sdram_mc_writer
// Purpose : Multi-channel AXI4-Stream to SDRAM write engine. Round-robin
//           arbitration at burst granularity, one write command per word,
//           bounded outstanding responses, one circular region per channel.
// Config  : AXIS_SDRAM_MC_WR_FRAME_SYNC_EN - when defined, an accepted word
//           with tlast reloads the channel pointer to its region base.
// Ports   : sdram_clk / sdram_rst      clock, synchronous active-high reset
//           s_tdata/tvalid/tlast/tready per-channel AXI4-Stream slaves
//           cfg_en/cfg_base/cfg_words  per-channel enable and region
//           sdram_cmd_*                write command port (rw tied 0)
//           sdram_resp_valid/ready     write completion (ready tied 1)
//           busy                       FSM active or responses pending
//           resp_err                   sticky unexpected-response flag
// Revision: 1.0 - initial release
// ============================================================================
module axis_sdram_mc_writer
  import axis_sdram_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 24,
  parameter int NUM_CH          = 4,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         sdram_clk,
  input  logic                         sdram_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  input  logic [NUM_CH-1:0]            cfg_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_words,
  output logic                         sdram_cmd_valid,
  output logic                         sdram_cmd_rw,
  output logic [ADDR_WIDTH-1:0]        sdram_cmd_addr,
  output logic [DATA_WIDTH-1:0]        sdram_cmd_wdata,
  input  logic                         sdram_cmd_ready,
  input  logic                         sdram_resp_valid,
  output logic                         sdram_resp_ready,
  output logic                         busy,
  output logic                         resp_err
);

  localparam int IDX_W = clog2_min1(NUM_CH);
  localparam int CNT_W = clog2_min1(BURST_LEN + 1);
  localparam int OUT_W = clog2_min1(MAX_OUTSTANDING + 1);

  wr_state_t             state;
  // rr_ptr doubles as the current grant: it is loaded with the winner on
  // every arbitration and is only consulted again at the next arbitration.
  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_CH-1:0]     gnt_oh;
  logic [CNT_W-1:0]      burst_cnt;
  logic [OUT_W-1:0]      outstanding;
  logic [ADDR_WIDTH-1:0] wr_ptr   [NUM_CH];
  logic [ADDR_WIDTH-1:0] base_ch  [NUM_CH];
  logic [ADDR_WIDTH-1:0] words_ch [NUM_CH];
  logic [DATA_WIDTH-1:0] data_ch  [NUM_CH];

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign base_ch[k]  = cfg_base[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign words_ch[k] = cfg_words[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_ch[k]  = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [NUM_CH-1:0] arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (cfg_en & s_tvalid),
    .last      (rr_ptr),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  logic                  sel_ok;
  logic                  sel_last;
  logic                  room;
  logic                  cmd_valid_int;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  wrap;
  logic                  burst_full;
  logic                  frame_reload;

  assign sel_ok        = s_tvalid[rr_ptr] && cfg_en[rr_ptr];
  assign sel_last      = s_tlast[rr_ptr];
  assign room          = (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign cmd_valid_int = (state == BURST) && sel_ok && room;
  assign accept        = cmd_valid_int && sdram_cmd_ready;
  assign ptr_next      = wr_ptr[rr_ptr] + ADDR_WIDTH'(1);
  // Region end compared modulo 2^ADDR_WIDTH, so regions may straddle the top.
  assign wrap          = (ptr_next == (base_ch[rr_ptr] + words_ch[rr_ptr]));
  assign burst_full    = (burst_cnt == CNT_W'(BURST_LEN - 1));

`ifdef AXIS_SDRAM_MC_WR_FRAME_SYNC_EN
  assign frame_reload  = sel_last;
`else
  assign frame_reload  = 1'b0;
`endif

  assign sdram_cmd_valid  = cmd_valid_int;
  assign sdram_cmd_rw     = 1'b0;
  assign sdram_cmd_addr   = wr_ptr[rr_ptr];
  assign sdram_cmd_wdata  = data_ch[rr_ptr];
  assign sdram_resp_ready = 1'b1;
  assign s_tready         = accept ? gnt_oh : '0;
  assign busy             = (state != IDLE) || (outstanding != '0);

  // Burst FSM: one arbitration cycle in IDLE, commands only in BURST.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_oh    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            rr_ptr    <= arb_idx;
            gnt_oh    <= arb_oh;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!sel_ok) begin
            state <= IDLE;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
            if (burst_full || sel_last || wrap) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response accounting; a completion with nothing in flight is flagged.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      outstanding <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (accept && !sdram_resp_valid) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!accept && sdram_resp_valid) begin
        if (outstanding == '0) resp_err    <= 1'b1;
        else                   outstanding <= outstanding - OUT_W'(1);
      end
    end
  end

  // Disabled channels continuously track their base so that a newly
  // enabled channel starts at the top of its region.
  always_ff @(posedge sdram_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (sdram_rst) begin
        wr_ptr[k] <= '0;
      end else if (!cfg_en[k]) begin
        wr_ptr[k] <= base_ch[k];
      end else if (accept && (rr_ptr == IDX_W'(k))) begin
        if (wrap || frame_reload) wr_ptr[k] <= base_ch[k];
        else                      wr_ptr[k] <= ptr_next;
      end
    end
  end

endmodule
`default_nettype wire
